// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the systolic-array sequencer.
// Contents:
//   phase_t      - phase encoding, also driven on state_out
//                  (IDLE=0, LOAD=1, COMPUTE=2, OUTPUT=3)
//   addr_width() - operand memory address width for an N x N array
//   cyc_width()  - compute-cycle counter width (3N-2 cycles)
//   idx_width()  - output index width (N*N results)
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } phase_t;

    // Never return zero, so that degenerate widths cannot produce empty vectors.
    function automatic int at_least_one(input int w);
        return (w < 1) ? 1 : w;
    endfunction

    // Weights and inputs share one memory: 2*N*N locations.
    function automatic int addr_width(input int n);
        return at_least_one($clog2(2 * n * n));
    endfunction

    // A wavefront crosses an N x N array in 3N-2 cycles.
    function automatic int cyc_width(input int n);
        return at_least_one($clog2(3 * n - 2));
    endfunction

    // One index per result element.
    function automatic int idx_width(input int n);
        return at_least_one($clog2(n * n));
    endfunction

endpackage

// File: rtl/tpu_step_counter.sv
// Up-counter used for the load address, the compute cycle and the output index.
// Parameters:
//   W    - counter width
//   TERM - terminal value reported on at_term
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (count resets to 0)
//   clear       - synchronous clear to 0 (highest priority)
//   load        - synchronous load of load_value
//   load_value  - value taken when load is high
//   en          - increment by one
//   count       - current value
//   at_term     - high while count equals TERM
module tpu_step_counter #(
    parameter int W    = 4,
    parameter int TERM = 15
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_term
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    // Clear beats load, load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign at_term = (count == TERM_V);

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Phase sequencer for an N x N systolic matrix-multiply unit.
// Walks the unit through LOAD (operand writes), COMPUTE (3N-2 MMU cycles)
// and OUTPUT (N*N results over a ready/valid handshake). Weights occupy
// addresses 0..N*N-1 and inputs N*N..2*N*N-1; with keep_w set and weights
// already resident, a job reloads only the inputs.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_en     - one operand element is on the write bus this cycle
//   keep_w      - reuse resident weights on the next job
//   out_ready   - downstream accepts the presented result
//   mem_we      - operand memory write strobe (combinational)
//   mem_addr    - operand memory write address
//   mmu_clear   - accumulator clear on the first compute cycle
//   mmu_en      - MMU advance enable
//   mmu_cycle   - current compute cycle index
//   out_valid   - a result is presented
//   out_idx     - row-major index of the presented result
//   done        - pulse when the last result is accepted
//   state_out   - current phase
module tpu_seq_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = addr_width(N),
    parameter int CYC_W  = cyc_width(N),
    parameter int IDX_W  = idx_width(N)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              keep_w,
    input  logic              out_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mmu_clear,
    output logic              mmu_en,
    output logic [CYC_W-1:0]  mmu_cycle,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic              done,
    output logic [1:0]        state_out
);

    localparam int NN     = N * N;
    localparam int A_LAST = 2 * NN - 1;
    localparam int C_LAST = 3 * N - 3;
    localparam int I_LAST = NN - 1;

    localparam logic [ADDR_W-1:0] INPUT_BASE  = ADDR_W'(NN);
    localparam logic [ADDR_W-1:0] LAST_WEIGHT = ADDR_W'(NN - 1);

    phase_t            state;
    logic              w_loaded;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_count;
    logic              addr_last;
    logic              addr_load;
    logic              addr_step;
    logic              cyc_last;
    logic              cyc_step;
    logic              cyc_wrap;
    logic              idx_last;
    logic              accept;
    logic              idx_step;
    logic              idx_wrap;

    // A job starts at the input half only when weights are already resident;
    // otherwise keep_w is ignored and the whole memory is reloaded.
    assign base = (keep_w && w_loaded) ? INPUT_BASE : '0;

    // The write strobe and its address must be valid in the same cycle as
    // load_en, so both are decoded combinationally. In IDLE the counter has
    // not been primed yet, so the base address is presented directly.
    assign mem_we   = load_en && ((state == IDLE) || (state == LOAD));
    assign mem_addr = (state == IDLE) ? base : addr_count;

    // The first write happens in IDLE, so the counter is primed with the
    // address after it. It stops at the last address and never wraps.
    assign addr_load = (state == IDLE) && load_en;
    assign addr_step = (state == LOAD) && load_en && !addr_last;

    tpu_step_counter #(
        .W    (ADDR_W),
        .TERM (A_LAST)
    ) u_addr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (1'b0),
        .load       (addr_load),
        .load_value (base + ADDR_W'(1)),
        .en         (addr_step),
        .count      (addr_count),
        .at_term    (addr_last)
    );

    // Cleared on its terminal cycle so every compute phase starts at 0.
    assign cyc_step = (state == COMPUTE);
    assign cyc_wrap = (state == COMPUTE) && cyc_last;

    tpu_step_counter #(
        .W    (CYC_W),
        .TERM (C_LAST)
    ) u_cyc_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cyc_wrap),
        .load       (1'b0),
        .load_value ('0),
        .en         (cyc_step),
        .count      (mmu_cycle),
        .at_term    (cyc_last)
    );

    // The index holds while the consumer stalls and returns to 0 once the
    // final result is taken.
    assign accept   = (state == OUTPUT) && out_ready;
    assign idx_step = accept && !idx_last;
    assign idx_wrap = accept && idx_last;

    tpu_step_counter #(
        .W    (IDX_W),
        .TERM (I_LAST)
    ) u_idx_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (idx_wrap),
        .load       (1'b0),
        .load_value ('0),
        .en         (idx_step),
        .count      (out_idx),
        .at_term    (idx_last)
    );

    // Phase register. The resident-weight flag is set when the last weight
    // address is written; a reset mid-load clears it so a partial weight set
    // is never reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w_loaded <= 1'b0;
        end else begin
            if (mem_we && (mem_addr == LAST_WEIGHT)) begin
                w_loaded <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_en && addr_last) begin
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (cyc_last) begin
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (idx_wrap) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything below derives from registered state, except done, which
    // marks the acceptance of the last result in the cycle it happens.
    assign mmu_en    = (state == COMPUTE);
    assign mmu_clear = (state == COMPUTE) && (mmu_cycle == '0);
    assign out_valid = (state == OUTPUT);
    assign done      = idx_wrap;
    assign state_out = state;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl: an N=2 instance covers full loads,
// weight reuse, backpressure and mid-load reset; an N=4 instance covers
// gapped loads and load_en outside the load phases.
module tb_tpu_seq_ctrl;

    logic clk;
    logic rst_n;

    // N=2 instance signals
    logic       a_load_en, a_keep_w, a_out_ready;
    logic       a_mem_we, a_mmu_clear, a_mmu_en, a_out_valid, a_done;
    logic [2:0] a_mem_addr;
    logic [1:0] a_mmu_cycle, a_out_idx, a_state;

    // N=4 instance signals
    logic       b_load_en, b_keep_w, b_out_ready;
    logic       b_mem_we, b_mmu_clear, b_mmu_en, b_out_valid, b_done;
    logic [4:0] b_mem_addr;
    logic [3:0] b_mmu_cycle, b_out_idx;
    logic [1:0] b_state;

    int total;
    int bad;

    tpu_seq_ctrl #(.N(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (a_load_en),
        .keep_w    (a_keep_w),
        .out_ready (a_out_ready),
        .mem_we    (a_mem_we),
        .mem_addr  (a_mem_addr),
        .mmu_clear (a_mmu_clear),
        .mmu_en    (a_mmu_en),
        .mmu_cycle (a_mmu_cycle),
        .out_valid (a_out_valid),
        .out_idx   (a_out_idx),
        .done      (a_done),
        .state_out (a_state)
    );

    tpu_seq_ctrl #(.N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (b_load_en),
        .keep_w    (b_keep_w),
        .out_ready (b_out_ready),
        .mem_we    (b_mem_we),
        .mem_addr  (b_mem_addr),
        .mmu_clear (b_mmu_clear),
        .mmu_en    (b_mmu_en),
        .mmu_cycle (b_mmu_cycle),
        .out_valid (b_out_valid),
        .out_idx   (b_out_idx),
        .done      (b_done),
        .state_out (b_state)
    );

    // Free-running clock, rising edge at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then settle before checks.
    task automatic applyStimulus(input int which, input logic le, input logic kw,
                                 input logic rdy);
        @(negedge clk);
        if (which == 2) begin
            a_load_en = le; a_keep_w = kw; a_out_ready = rdy;
        end else begin
            b_load_en = le; b_keep_w = kw; b_out_ready = rdy;
        end
        #1;
    endtask

    task automatic checkIdle2(input string tag);
        checkOutput({tag, ".state"}, 32'(a_state), 0);
        checkOutput({tag, ".we"}, 32'(a_mem_we), 0);
        checkOutput({tag, ".mmu_en"}, 32'(a_mmu_en), 0);
        checkOutput({tag, ".valid"}, 32'(a_out_valid), 0);
        checkOutput({tag, ".done"}, 32'(a_done), 0);
    endtask

    // One N=2 job: loads from base, 4 compute cycles, 4 outputs. stall_at
    // names an output index held for 3 cycles with out_ready low (-1: none).
    task automatic runJob2(input string tag, input logic kw, input int base,
                           input int stall_at);
        int nloads;
        nloads = (base == 0) ? 8 : 4;
        for (int i = 0; i < nloads; i++) begin
            applyStimulus(2, 1'b1, kw, 1'b1);
            checkOutput({tag, ".load_we"}, 32'(a_mem_we), 1);
            checkOutput({tag, ".load_addr"}, 32'(a_mem_addr), 32'(base + i));
            checkOutput({tag, ".load_state"}, 32'(a_state), (i == 0) ? 0 : 1);
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2, 1'b0, kw, 1'b1);
            checkOutput({tag, ".cmp_state"}, 32'(a_state), 2);
            checkOutput({tag, ".cmp_en"}, 32'(a_mmu_en), 1);
            checkOutput({tag, ".cmp_cycle"}, 32'(a_mmu_cycle), 32'(c));
            checkOutput({tag, ".cmp_clear"}, 32'(a_mmu_clear), (c == 0) ? 1 : 0);
            checkOutput({tag, ".cmp_valid"}, 32'(a_out_valid), 0);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    applyStimulus(2, 1'b0, kw, 1'b0);
                    checkOutput({tag, ".stall_valid"}, 32'(a_out_valid), 1);
                    checkOutput({tag, ".stall_idx"}, 32'(a_out_idx), 32'(k));
                    checkOutput({tag, ".stall_done"}, 32'(a_done), 0);
                end
            end
            applyStimulus(2, 1'b0, kw, 1'b1);
            checkOutput({tag, ".out_state"}, 32'(a_state), 3);
            checkOutput({tag, ".out_valid"}, 32'(a_out_valid), 1);
            checkOutput({tag, ".out_idx"}, 32'(a_out_idx), 32'(k));
            checkOutput({tag, ".out_done"}, 32'(a_done), (k == 3) ? 1 : 0);
            checkOutput({tag, ".out_en"}, 32'(a_mmu_en), 0);
        end
        applyStimulus(2, 1'b0, 1'b0, 1'b1);
        checkIdle2({tag, ".end"});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a_load_en = 1'b0; a_keep_w = 1'b0; a_out_ready = 1'b0;
        b_load_en = 1'b0; b_keep_w = 1'b0; b_out_ready = 1'b0;

        // Reset values
        #12;
        checkIdle2("rst");
        checkOutput("rst.addr", 32'(a_mem_addr), 0);
        checkOutput("rst.cycle", 32'(a_mmu_cycle), 0);
        checkOutput("rst.idx", 32'(a_out_idx), 0);
        checkOutput("rst.clear", 32'(a_mmu_clear), 0);
        checkOutput("rst4.state", 32'(b_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // keep_w straight after reset: no resident weights, full load
        runJob2("keep_cold", 1'b1, 0, -1);
        // plain full job
        runJob2("full", 1'b0, 0, -1);
        // weight reuse: inputs only
        runJob2("reuse", 1'b1, 4, -1);
        // output backpressure at index 1, still reusing weights
        runJob2("bp", 1'b1, 4, 1);

        // Reset after 5 of 8 loads discards the partial job and the weights
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, 1'b1, 1'b0, 1'b1);
            checkOutput("part.addr", 32'(a_mem_addr), 32'(i));
        end
        a_load_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkIdle2("midrst");
        checkOutput("midrst.addr", 32'(a_mem_addr), 0);
        checkOutput("midrst.cycle", 32'(a_mmu_cycle), 0);
        checkOutput("midrst.idx", 32'(a_out_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // keep_w=1 must be ignored: weight flag was cleared
        runJob2("after_rst", 1'b1, 0, -1);

        // N=4: 32 writes with gaps before every third element
        for (int i = 0; i < 32; i++) begin
            if ((i % 3) == 1) begin
                applyStimulus(4, 1'b0, 1'b0, 1'b1);
                checkOutput("n4.gap_we", 32'(b_mem_we), 0);
                checkOutput("n4.gap_state", 32'(b_state), 1);
            end
            applyStimulus(4, 1'b1, 1'b0, 1'b1);
            checkOutput("n4.we", 32'(b_mem_we), 1);
            checkOutput("n4.addr", 32'(b_mem_addr), 32'(i));
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4, (c == 2) || (c == 5), 1'b0, 1'b1);
            checkOutput("n4.cmp_state", 32'(b_state), 2);
            checkOutput("n4.cmp_cycle", 32'(b_mmu_cycle), 32'(c));
            checkOutput("n4.cmp_clear", 32'(b_mmu_clear), (c == 0) ? 1 : 0);
            checkOutput("n4.cmp_we", 32'(b_mem_we), 0);
        end
        for (int k = 0; k < 16; k++) begin
            // load_en alongside done must be ignored
            applyStimulus(4, (k == 15), 1'b0, 1'b1);
            checkOutput("n4.out_valid", 32'(b_out_valid), 1);
            checkOutput("n4.out_idx", 32'(b_out_idx), 32'(k));
            checkOutput("n4.out_done", 32'(b_done), (k == 15) ? 1 : 0);
            checkOutput("n4.out_we", 32'(b_mem_we), 0);
        end
        applyStimulus(4, 1'b0, 1'b0, 1'b1);
        checkOutput("n4.end_state", 32'(b_state), 0);
        checkOutput("n4.end_valid", 32'(b_out_valid), 0);
        checkOutput("n4.end_addr", 32'(b_mem_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
